// File: rtl/ahb_pkg.sv
`default_nettype none
// =============================================================================
// Module      : ahb_pkg
// Description : AHB bus enumerations, constants and the byte-lane mask helper
//               shared by the ahb_slave_mem slice.
// Revision    : 1.0 - initial release
// =============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_t;

  localparam int unsigned MAX_LANES = 16;

  // Lanes touched by a transfer of 2**size bytes starting at byte lane 'lane'.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [3:0] lane,
                                                     input logic [2:0] size);
    logic [31:0] w_bits;
    w_bits = (32'h1 << (32'h1 << size)) - 32'h1;
    return MAX_LANES'(w_bits << lane);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_mem_ram.sv
`default_nettype none
// =============================================================================
// Module      : ahb_slave_mem_ram
// Description : DEPTH x DATA_WDT storage, one byte-enabled write port and one
//               asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// =============================================================================
module ahb_slave_mem_ram #(
  parameter int unsigned DATA_WDT = 32,
  parameter int unsigned DEPTH    = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [DATA_WDT/8-1:0]      i_be,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_WDT-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_WDT-1:0]        o_rdata
);

  logic [DATA_WDT-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WDT/8; b++) begin
        if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// =============================================================================
// Module      : ahb_slave_mem
// Description : AHB slave RAM with byte lanes, NONSEQ/SEQ wait states and a
//               two-cycle ERROR response. Define AHB_SLAVE_RAND_WAIT_EN to add
//               0..3 LFSR-driven extra wait states per transfer.
// Revision    : 1.0 - initial release
// =============================================================================
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WDT  = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned NSEQ_WAIT = 0,
  parameter int unsigned SEQ_WAIT  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp
);

  localparam int unsigned c_NB       = DATA_WDT / 8;
  localparam int unsigned c_ADDR_LSB = $clog2(c_NB);
  localparam int unsigned c_AW       = $clog2(DEPTH);
  localparam logic [32:0] c_ADDR_LO  = {1'b0, BASE_ADDR};
  localparam logic [32:0] c_ADDR_HI  = c_ADDR_LO + 33'(DEPTH * c_NB);

  slv_state_t            r_state, w_state_nxt;
  logic [4:0]            r_cnt, w_cnt_nxt;
  logic [31:0]           r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [DATA_WDT-1:0]   r_rdata_hold;

  logic                  w_accept, w_err;
  logic [3:0]            w_base_wait;
  logic [4:0]            w_wait_load;
  logic [31:0]           w_off;
  logic [c_AW-1:0]       w_word_idx;
  logic [MAX_LANES-1:0]  w_mask16;
  logic [DATA_WDT-1:0]   w_ram_rdata;
  logic                  w_ram_we;
  logic                  w_unused;

  assign w_accept = i_hsel & i_hready & i_htrans[1];

  // 33-bit compare so a window ending at 4 GiB cannot wrap.
  assign w_err = ({1'b0, i_haddr} < c_ADDR_LO) || ({1'b0, i_haddr} >= c_ADDR_HI) ||
                 (i_hsize > 3'(c_ADDR_LSB)) ||
                 ((i_haddr & ((32'h1 << i_hsize) - 32'h1)) != 32'h0);

  assign w_base_wait = (i_htrans == HTRANS_SEQ) ? 4'(SEQ_WAIT) : 4'(NSEQ_WAIT);

`ifdef AHB_SLAVE_RAND_WAIT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n)  r_lfsr <= LFSR_SEED;
    else if (w_accept) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign w_wait_load = {1'b0, w_base_wait} + {3'b000, r_lfsr[1:0]};
`else
  assign w_wait_load = {1'b0, w_base_wait};
`endif

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 5'd0;
      r_addr       <= 32'h0;
      r_write      <= 1'b0;
      r_size       <= 3'd0;
      r_rdata_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= i_haddr;
        r_write <= i_hwrite;
        r_size  <= i_hsize;
      end
      if (r_state == ST_DATA && !r_write) r_rdata_hold <= w_ram_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_hready    = 1'b1;
    o_hresp     = HRESP_OKAY;
    case (r_state)
      ST_WAIT: begin
        o_hready  = 1'b0;
        w_cnt_nxt = r_cnt - 5'd1;
        if (r_cnt <= 5'd1) w_state_nxt = ST_DATA;
      end
      ST_ERR1: begin
        o_hready    = 1'b0;
        o_hresp     = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all present hready=1 and may take a new address phase.
        if (r_state == ST_ERR2) o_hresp = HRESP_ERROR;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 5'd0;
        if (w_accept) begin
          if (w_err)                    w_state_nxt = ST_ERR1;
          else if (w_wait_load == 5'd0) w_state_nxt = ST_DATA;
          else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = w_wait_load;
          end
        end
      end
    endcase
  end

  assign w_off      = r_addr - BASE_ADDR;
  assign w_word_idx = c_AW'(w_off >> c_ADDR_LSB);
  assign w_mask16   = lane_mask(4'(w_off[c_ADDR_LSB-1:0]), r_size);
  assign w_ram_we   = (r_state == ST_DATA) && r_write;

  ahb_slave_mem_ram #(
    .DATA_WDT (DATA_WDT),
    .DEPTH    (DEPTH)
  ) u_ram (
    .i_clk   (i_hclk),
    .i_we    (w_ram_we),
    .i_be    (w_mask16[c_NB-1:0]),
    .i_waddr (w_word_idx),
    .i_wdata (i_hwdata),
    .i_raddr (w_word_idx),
    .o_rdata (w_ram_rdata)
  );

  assign o_hrdata = (r_state == ST_DATA && !r_write)              ? w_ram_rdata :
                    (r_state == ST_ERR1 || r_state == ST_ERR2)    ? '0          :
                                                                    r_rdata_hold;

  assign w_unused = ^{i_hburst, w_mask16, LFSR_SEED};

endmodule
`default_nettype wire
